// File: rtl/hamming_sec_pkg.sv
// hamming_sec_pkg: (12,8) single-error-correcting codeword layout, syndrome constants and helpers.
package hamming_sec_pkg;
    localparam int CODE_W = 12;
    localparam int DATA_W = 8;
    localparam int SYN_W = 4;
    localparam int C_P0 = 0, C_P1 = 1, C_D0 = 2, C_P2 = 3, C_D1 = 4, C_D2 = 5;
    localparam int C_D3 = 6, C_P3 = 7, C_D4 = 8, C_D5 = 9, C_D6 = 10, C_D7 = 11;
    localparam logic [SYN_W-1:0] SYN_OK = 4'b0000;
    localparam logic [SYN_W-1:0] SYN_MAX_MAPPED = 4'b1100;
    localparam logic [SYN_W-1:0] SYN_UNC_A = 4'b1101;
    localparam logic [SYN_W-1:0] SYN_UNC_B = 4'b1110;
    localparam logic [SYN_W-1:0] SYN_UNC_C = 4'b1111;

    // Positional Hamming code: a nonzero syndrome n names codeword bit n-1.
    function automatic logic [CODE_W-1:0] flip_mask(input logic [SYN_W-1:0] syn);
        return (syn != SYN_OK && syn <= SYN_MAX_MAPPED) ? CODE_W'(1) << (syn - 4'd1) : '0;
    endfunction

    function automatic logic is_uncorrectable(input logic [SYN_W-1:0] syn);
        return syn == SYN_UNC_A || syn == SYN_UNC_B || syn == SYN_UNC_C;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        return {c[C_D7], c[C_D6], c[C_D5], c[C_D4], c[C_D3], c[C_D2], c[C_D1], c[C_D0]};
    endfunction
endpackage

// File: rtl/hamming_sec_decoder_pipe_syndrome.sv
// hamming_sec_syndrome: combinational syndrome of a received 12-bit codeword.
module hamming_sec_syndrome
    import hamming_sec_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syndrome
);
    assign syndrome = {
        ^{code[11:7]},
        ^{code[11], code[6:3]},
        ^{code[10:9], code[6:5], code[2:1]},
        ^{code[10], code[8], code[6], code[4], code[2], code[0]}
    };
endmodule

// File: rtl/hamming_sec_decoder_pipe.sv
// hamming_sec_decoder_pipe: 2-stage valid/ready SEC decoder with saturating
// corrected/uncorrectable event counters.
module hamming_sec_decoder_pipe
    import hamming_sec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [3:0]        out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    input  logic              clr_counts,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);
    logic              s1_valid, s2_valid, s1_adv, fire;
    logic [CODE_W-1:0] s1_code, fixed;
    logic [SYN_W-1:0]  syn, s1_syn;

    hamming_sec_syndrome u_syn (.code(in_code), .syndrome(syn));

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;
    assign fire      = s2_valid && out_ready;
    assign fixed     = s1_code ^ flip_mask(s1_syn);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid          <= 1'b0;
            s2_valid          <= 1'b0;
            out_data          <= '0;
            out_syndrome      <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            corr_count        <= '0;
            uncorr_count      <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_code <= in_code;
                s1_syn  <= syn;
            end
            if (s1_adv) s2_valid <= s1_valid;
            if (s1_valid && s1_adv) begin
                out_data          <= extract_data(fixed);
                out_syndrome      <= s1_syn;
                out_corrected     <= flip_mask(s1_syn) != '0;
                out_uncorrectable <= is_uncorrectable(s1_syn);
            end
            // Counters follow the word being handed off; clear wins over increment.
            corr_count   <= clr_counts ? '0 :
                            (fire && out_corrected && !(&corr_count)) ? corr_count + 1'b1 : corr_count;
            uncorr_count <= clr_counts ? '0 :
                            (fire && out_uncorrectable && !(&uncorr_count)) ? uncorr_count + 1'b1 : uncorr_count;
        end
    end
endmodule

// File: doc/hamming_sec_decoder_pipe.md
HAMMING_SEC_DECODER_PIPE -- requirements
Module: hamming_sec_decoder_pipe

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of each saturating error counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream codeword valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts in_code this cycle.
REQ-006 SHALL have port: in_code  input  12  received codeword.
REQ-007 SHALL have port: out_valid  output  1  output word valid.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts output.
REQ-009 SHALL have port: out_data  output  8  decoded (corrected when possible) data.
REQ-010 SHALL have port: out_syndrome  output  4  syndrome {s3,s2,s1,s0} of the word.
REQ-011 SHALL have port: out_corrected  output  1  single-bit error found and fixed.
REQ-012 SHALL have port: out_uncorrectable  output  1  syndrome in 1101/1110/1111.
REQ-013 SHALL have port: clr_counts  input  1  synchronous clear of both counters.
REQ-014 SHALL have ports: corr_count and uncorr_count  output  CNT_W  saturating event counts.

Function
REQ-015 SHALL use codeword layout: c11..c8=d7..d4, c7=p3, c6..c4=d3..d1, c3=p2, c2=d0, c1=p1, c0=p0.
REQ-016 SHALL compute s3=c11^c10^c9^c8^c7; s2=c11^c6^c5^c4^c3; s1=c10^c9^c6^c5^c2^c1; s0=c10^c8^c6^c4^c2^c0.
REQ-017 SHALL map syndrome to flipped bit: 1100->c11, 1011->c10, 1010->c9, 1001->c8, 1000->c7, 0111->c6, 0110->c5, 0101->c4, 0100->c3, 0011->c2, 0010->c1, 0001->c0.
REQ-018 SHALL, for syndrome 0000, output extracted data unchanged, corrected=0, uncorrectable=0.
REQ-019 SHALL, for mapped nonzero syndrome, invert that bit before data extraction and set corrected=1 (parity-bit hits give unchanged data, corrected=1).
REQ-020 SHALL, for syndrome 1101/1110/1111, output raw extracted data, corrected=0, uncorrectable=1.
REQ-021 SHALL be a 2-stage pipeline: stage 1 registers codeword+syndrome, stage 2 registers data+flags; latency exactly 2 cycles with no stalls.
REQ-022 SHALL drive in_ready = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready (combinational, no in_valid dependence).
REQ-023 SHALL sustain one word per cycle while out_ready=1; hold all outputs stable while out_valid=1 and out_ready=0.
REQ-024 SHALL never drop or duplicate a word; order preserved.
REQ-025 SHALL increment corr_count/uncorr_count on out_valid&&out_ready when the respective flag is set, saturating at all-ones.
REQ-026 SHALL give clr_counts priority over a same-cycle increment (counter reads 0 next cycle).

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear both stage valids, counters, out_data, out_syndrome, out_corrected, out_uncorrectable to 0.
REQ-028 SHALL discard in-flight words on mid-operation reset; in_ready=1 the cycle after rst deasserts.

Structure
REQ-029 SHALL place codeword bit positions, syndrome constants (incl. uncorrectable set) and the syndrome-to-bit map function in package hamming_sec_pkg.
REQ-030 SHALL instantiate one combinational sub-module hamming_sec_syndrome (12-bit code in, 4-bit syndrome out).

Verification
REQ-031 SHALL cover: in_code=0xA27 (d=0xA5) -> 2 cycles later out_data=0xA5, syndrome=0000, flags 0.
REQ-032 SHALL cover: in_code=0xA07 (c5 flipped) -> out_data=0xA5, syndrome=0110, corrected=1, corr_count+1.
REQ-033 SHALL cover: in_code=0x226 (c11,c0 flipped) -> syndrome=1101, uncorrectable=1, out_data=0x25, uncorr_count+1.
REQ-034 SHALL cover: 4 back-to-back words with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 once both stages full, all 4 delivered in order, outputs stable during stall.
REQ-035 SHALL cover: CNT_W=4, 17 corrected words -> corr_count holds 0xF; clr_counts with same-cycle corrected handshake -> 0.
REQ-036 SHALL cover: rst asserted with both stages full -> out_valid=0 next cycle, counters 0, no stale word emitted.
